// File: rtl/qerv_rf_arb_pkg.sv
// Shared types and default geometry for the register-file RAM arbiter.
// Defaults assume a 1-bit core (W=1) and four CSR slots in the RF RAM.
package qerv_rf_arb_pkg;

  localparam int RF_W         = 1;
  localparam int CSR_REGS     = 4;
  localparam int DEF_WIDTH    = 2 * RF_W;
  localparam int DEF_ADDR_W   = $clog2((32 + CSR_REGS) * 32 / DEF_WIDTH);
  localparam int DEF_HOLD_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/qerv_rf_ram_arb.sv
// Core/host arbiter for the RF RAM: the core always wins, the host fills idle port cycles.
// Optional starvation status counter enabled by defining QERV_RF_ARB_STARVE_EN.
module qerv_rf_ram_arb
  import qerv_rf_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_c_waddr,
  input  logic [WIDTH-1:0]  i_c_wdata,
  input  logic              i_c_wen,
  input  logic [ADDR_W-1:0] i_c_raddr,
  input  logic              i_c_ren,
  output logic [WIDTH-1:0]  o_c_rdata,
  input  logic              i_h_req,
  input  logic              i_h_we,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [WIDTH-1:0]  i_h_wdata,
  output logic              o_h_ack,
  output logic [WIDTH-1:0]  o_h_rdata,
  output logic              o_h_busy,
  output logic              o_h_starve,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [WIDTH-1:0]  o_ram_wdata,
  output logic              o_ram_wen,
  output logic [ADDR_W-1:0] o_ram_raddr,
  output logic              o_ram_ren,
  input  logic [WIDTH-1:0]  i_ram_rdata
);

  arb_state_e        state_q, state_d;
  logic              h_we_q, h_we_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d;
  logic [WIDTH-1:0]  h_wdata_q, h_wdata_d;
  logic [WIDTH-1:0]  h_rdata_q, h_rdata_d;
  logic              host_wr, host_rd;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    h_we_d    = h_we_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;
    h_rdata_d = h_rdata_q;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_h_req) begin
          h_we_d    = i_h_we;
          h_addr_d  = i_h_addr;
          h_wdata_d = i_h_wdata;
          state_d   = ST_PEND;
        end
      end
      // Each host access waits only on its own RAM port.
      ST_PEND: begin
        if (h_we_q) begin
          if (!i_c_wen) begin
            host_wr = 1'b1;
            state_d = ST_ACK;
          end
        end else if (!i_c_ren) begin
          host_rd = 1'b1;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        h_rdata_d = i_ram_rdata;
        state_d   = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      h_we_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      state_q   <= state_d;
      h_we_q    <= h_we_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  // Core traffic passes straight through; the host only fills an idle port.
  assign o_ram_wen   = i_c_wen | host_wr;
  assign o_ram_waddr = i_c_wen ? i_c_waddr : h_addr_q;
  assign o_ram_wdata = i_c_wen ? i_c_wdata : h_wdata_q;
  assign o_ram_ren   = i_c_ren | host_rd;
  assign o_ram_raddr = i_c_ren ? i_c_raddr : h_addr_q;
  assign o_c_rdata   = i_ram_rdata;

  assign o_h_ack   = (state_q == ST_ACK);
  assign o_h_busy  = (state_q != ST_IDLE);
  assign o_h_rdata = h_rdata_q;

`ifdef QERV_RF_ARB_STARVE_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_q, starve_d;

  always_comb begin
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (state_q == ST_IDLE && state_d == ST_PEND) begin
      cnt_d = '0;
    end else if (state_q == ST_PEND) begin
      if (cnt_q != CNT_W'(HOLD_MAX)) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(HOLD_MAX)) starve_d = 1'b1;
    end else if (state_q == ST_ACK) begin
      starve_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign o_h_starve = starve_q;
`else
  logic unused_hold_max;
  assign unused_hold_max = (HOLD_MAX > 0);
  assign o_h_starve      = 1'b0;
`endif

endmodule

// File: tb/tb_qerv_rf_ram_arb.sv
// Scoreboard bench for qerv_rf_ram_arb: directed host/core traffic against a behavioural RAM.
// Host acks are checked by a monitor against expected cycle and read data queued at issue time.
module tb_qerv_rf_ram_arb;

  localparam int WIDTH  = 2;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] c_waddr, c_raddr, h_addr;
  logic [WIDTH-1:0]  c_wdata, h_wdata;
  logic              c_wen, c_ren, h_req, h_we;
  logic [WIDTH-1:0]  c_rdata, h_rdata, ram_wdata, ram_rdata;
  logic              h_ack, h_busy, h_starve;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic              ram_wen, ram_ren;

  qerv_rf_ram_arb dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_c_waddr   (c_waddr),
    .i_c_wdata   (c_wdata),
    .i_c_wen     (c_wen),
    .i_c_raddr   (c_raddr),
    .i_c_ren     (c_ren),
    .o_c_rdata   (c_rdata),
    .i_h_req     (h_req),
    .i_h_we      (h_we),
    .i_h_addr    (h_addr),
    .i_h_wdata   (h_wdata),
    .o_h_ack     (h_ack),
    .o_h_rdata   (h_rdata),
    .o_h_busy    (h_busy),
    .o_h_starve  (h_starve),
    .o_ram_waddr (ram_waddr),
    .o_ram_wdata (ram_wdata),
    .o_ram_wen   (ram_wen),
    .o_ram_raddr (ram_raddr),
    .o_ram_ren   (ram_ren),
    .i_ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RF RAM with one cycle of read latency.
  logic [WIDTH-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit               is_rd;
    logic [WIDTH-1:0] data;
    int               cyc;
    int               tag;
  } exp_t;
  exp_t sbq[$];
  int   tag_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ack is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && h_ack) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected: ack at cycle %0d, required no ack", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (cyc != e.cyc || (e.is_rd && h_rdata !== e.data)) begin
          n_err++;
          $display("FAIL ack#%0d: cycle %0d rdata 0x%0h, required cycle %0d rdata 0x%0h",
                   e.tag, cyc, h_rdata, e.cyc, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of a cycle; the request is presented in this cycle.
  task automatic issue(input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [WIDTH-1:0] wd, input int lat, input logic [WIDTH-1:0] rd);
    exp_t e;
    h_req   = 1'b1;
    h_we    = we;
    h_addr  = addr;
    h_wdata = wd;
    e.is_rd = !we;
    e.data  = rd;
    e.cyc   = cyc + lat;
    e.tag   = tag_cnt++;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!h_busy) done = 1'b1;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic host_op(input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [WIDTH-1:0] wd, input int lat, input logic [WIDTH-1:0] rd,
                         input string name);
    issue(we, addr, wd, lat, rd);
    tick();
    h_req = 1'b0;
    wait_done(name);
  endtask

  function automatic bit exp_starve(input int k);
`ifdef QERV_RF_ARB_STARVE_EN
    return (k >= 16 && k <= 22);
`else
    return (k < 0);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {c_wen, c_ren, h_req, h_we} = '0;
    c_waddr = '0; c_raddr = '0; h_addr = '0;
    c_wdata = '0; h_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",    32'(h_ack),    32'd0);
    check("rst_busy",   32'(h_busy),   32'd0);
    check("rst_starve", 32'(h_starve), 32'd0);
    check("rst_rdata",  32'(h_rdata),  32'd0);
    check("rst_ram_en", 32'({ram_wen, ram_ren}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Host write, core idle: RAM write in cycle 1, ack in cycle 2.
    issue(1'b1, 10'h005, 2'b11, 2, 2'b00);
    @(negedge clk);
    check("wr_busy_c0", 32'(h_busy), 32'd0);
    tick();
    h_req = 1'b0;
    @(negedge clk);
    check("wr_wen_c1",   32'(ram_wen),   32'd1);
    check("wr_waddr_c1", 32'(ram_waddr), 32'h005);
    check("wr_wdata_c1", 32'(ram_wdata), 32'd3);
    check("wr_busy_c1",  32'(h_busy),    32'd1);
    wait_done("wr5");
    host_op(1'b0, 10'h005, 2'b00, 3, 2'b11, "rd5");

    // Preload 0x120 through the core write port.
    c_wen = 1'b1; c_waddr = 10'h120; c_wdata = 2'b10;
    @(negedge clk);
    check("core_waddr", 32'(ram_waddr), 32'h120);
    check("core_wdata", 32'(ram_wdata), 32'd2);
    tick();
    c_wen = 1'b0;

    // Host read, core idle: RAM read in cycle 1, ack with data in cycle 3.
    issue(1'b0, 10'h120, 2'b00, 3, 2'b10);
    tick();
    h_req = 1'b0;
    @(negedge clk);
    check("rd_ren_c1",   32'(ram_ren),   32'd1);
    check("rd_raddr_c1", 32'(ram_raddr), 32'h120);
    wait_done("rd120");

    // Core write held 6 cycles blocks a host write to 0x007.
    issue(1'b1, 10'h007, 2'b01, 7, 2'b00);
    for (int k = 0; k < 6; k++) begin
      if (k == 1) h_req = 1'b0;
      c_wen = 1'b1; c_waddr = 10'(10'h300 + k); c_wdata = 2'b10;
      @(negedge clk);
      check($sformatf("blk_waddr_%0d", k), 32'(ram_waddr), 32'(10'h300 + k));
      check($sformatf("blk_wdata_%0d", k), 32'(ram_wdata), 32'd2);
      tick();
    end
    c_wen = 1'b0;
    @(negedge clk);
    check("blk_host_wen",   32'(ram_wen),   32'd1);
    check("blk_host_waddr", 32'(ram_waddr), 32'h007);
    wait_done("blk7");
    host_op(1'b0, 10'h007, 2'b00, 3, 2'b01, "rd7");

    // Same-address conflict: core writes 0x00A first, host value lands later.
    issue(1'b1, 10'h00A, 2'b01, 3, 2'b00);
    tick();
    h_req = 1'b0;
    c_wen = 1'b1; c_waddr = 10'h00A; c_wdata = 2'b10;
    @(negedge clk);
    check("conf_core_wdata", 32'(ram_wdata), 32'd2);
    tick();
    c_wen = 1'b0;
    @(negedge clk);
    check("conf_host_wdata", 32'(ram_wdata), 32'd1);
    wait_done("confA");
    host_op(1'b0, 10'h00A, 2'b00, 3, 2'b01, "rdA");

    // Independent ports: core writes every cycle, core reads during RD.
    issue(1'b0, 10'h120, 2'b00, 3, 2'b10);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) h_req = 1'b0;
      c_wen = 1'b1; c_waddr = 10'(10'h200 + k); c_wdata = 2'(k);
      c_ren = (k == 2); c_raddr = 10'h005;
      @(negedge clk);
      check($sformatf("ind_waddr_%0d", k), 32'(ram_waddr), 32'(10'h200 + k));
      if (k == 1) check("ind_host_raddr", 32'(ram_raddr), 32'h120);
      if (k == 2) check("ind_core_raddr", 32'(ram_raddr), 32'h005);
      if (k == 3) check("ind_core_rdata", 32'(c_rdata), 32'd3);
      tick();
    end
    c_wen = 1'b0; c_ren = 1'b0;
    wait_done("ind");

    // Core reads block a host read for 3 cycles.
    issue(1'b0, 10'h005, 2'b00, 5, 2'b11);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) h_req = 1'b0;
      c_ren = 1'b1; c_raddr = 10'h120;
      @(negedge clk);
      check($sformatf("rblk_raddr_%0d", k), 32'(ram_raddr), 32'h120);
      tick();
    end
    c_ren = 1'b0;
    @(negedge clk);
    check("rblk_host_raddr", 32'(ram_raddr), 32'h005);
    wait_done("rblk");

    // Host inputs change while busy: latched request still executes.
    issue(1'b1, 10'h00B, 2'b11, 4, 2'b00);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        h_req = 1'b0; h_we = 1'b0; h_addr = 10'h00C; h_wdata = 2'b00;
      end
      c_wen = 1'b1; c_waddr = 10'h3F0; c_wdata = 2'b00;
      tick();
    end
    c_wen = 1'b0;
    @(negedge clk);
    check("chg_wen",   32'(ram_wen),   32'd1);
    check("chg_waddr", 32'(ram_waddr), 32'h00B);
    check("chg_wdata", 32'(ram_wdata), 32'd3);
    wait_done("chg");
    host_op(1'b0, 10'h00B, 2'b00, 3, 2'b11, "rdB");

    // Long core read burst: 19 PEND cycles, starvation flag only with the option built.
    issue(1'b0, 10'h120, 2'b00, 22, 2'b10);
    for (int k = 0; k < 24; k++) begin
      if (k == 1) h_req = 1'b0;
      c_ren = (k < 20); c_raddr = 10'h100;
      @(negedge clk);
      if (k == 15 || k == 16 || k == 22 || k == 23)
        check($sformatf("starve_c%0d", k), 32'(h_starve), 32'(exp_starve(k)));
      if (k == 20) check("starve_host_raddr", 32'(ram_raddr), 32'h120);
      tick();
    end
    c_ren = 1'b0;
    wait_done("starve");

    // Reset while in RD: outputs drop at once, no host access after release.
    issue(1'b0, 10'h005, 2'b00, 3, 2'b11);
    tick();
    h_req = 1'b0;
    tick();
    @(negedge clk);
    sbq.delete();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",    32'(h_ack),    32'd0);
    check("mid_rst_busy",   32'(h_busy),   32'd0);
    check("mid_rst_starve", 32'(h_starve), 32'd0);
    check("mid_rst_rdata",  32'(h_rdata),  32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_en_%0d", k), 32'({ram_wen, ram_ren, h_ack}), 32'd0);
      tick();
    end

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qerv_rf_ram_arb.md
Name: qerv_rf_ram_arb

Overview:
- Two-way arbiter for the register-file RAM: one write port, one read port, registered read data with 1-cycle latency.
- Shares the RAM between the core's RF RAM interface and a host/debug port that reads and writes registers while the core runs.
- The core has absolute priority and is never stalled. The host uses a port only in cycles when the core leaves that port idle.
- Sits between the core's RF RAM interface and the RF RAM instance in the RF top level.

Parameters:
WIDTH, 2, RAM data width in bits (equal to RF_WIDTH = 2*W)
ADDR_W, 10, RAM address width; default covers (32+4)*32/2 = 576 entries
HOLD_MAX, 15, starvation threshold in cycles; used only with QERV_RF_ARB_STARVE_EN

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_c_waddr  in  ADDR_W  core write address
i_c_wdata  in  WIDTH  core write data
i_c_wen  in  1  core write enable
i_c_raddr  in  ADDR_W  core read address
i_c_ren  in  1  core read enable
o_c_rdata  out  WIDTH  core read data, direct from i_ram_rdata
i_h_req  in  1  host request, level
i_h_we  in  1  host request is a write
i_h_addr  in  ADDR_W  host address
i_h_wdata  in  WIDTH  host write data
o_h_ack  out  1  one-cycle completion pulse
o_h_rdata  out  WIDTH  host read data, valid while o_h_ack is high
o_h_busy  out  1  a host request is latched and not yet acknowledged
o_h_starve  out  1  starvation flag; constant 0 without the macro
o_ram_waddr  out  ADDR_W  RAM write address
o_ram_wdata  out  WIDTH  RAM write data
o_ram_wen  out  1  RAM write enable
o_ram_raddr  out  ADDR_W  RAM read address
o_ram_ren  out  1  RAM read enable
i_ram_rdata  in  WIDTH  RAM read data, valid 1 cycle after ren

Behaviour:
- Clocking and reset: single clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset state:
  - FSM in IDLE.
  - o_h_ack, o_h_busy and o_h_starve are 0.
  - o_h_rdata is 0.
  - Latched request registers are 0.
- Core pass-through (combinational):
  - When i_c_wen=1, the RAM write port carries the core write.
  - When i_c_ren=1, the RAM read port carries the core read.
  - o_c_rdata = i_ram_rdata at all times.
  - The core sees identical timing with or without host traffic.
- The two RAM ports are arbitrated independently:
  - A host write needs only i_c_wen=0.
  - A host read needs only i_c_ren=0.
- FSM states: IDLE, PEND, RD, ACK.
  - IDLE:
    - i_h_req is sampled here only.
    - On i_h_req=1, latch we/addr/wdata and go to PEND; o_h_busy rises the next cycle.
  - PEND, write:
    - If i_c_wen=0, drive o_ram_wen=1 with the latched addr/data and go to ACK.
    - Otherwise stay in PEND.
  - PEND, read:
    - If i_c_ren=0, drive o_ram_ren=1 with the latched addr and go to RD.
    - Otherwise stay in PEND.
  - RD:
    - Register i_ram_rdata into o_h_rdata and go to ACK.
    - The core may use the read port in this cycle; the host data is unaffected.
  - ACK:
    - o_h_ack=1 for exactly this cycle; then IDLE and o_h_busy=0.
    - i_h_req is ignored in ACK.
    - The host must deassert i_h_req by the cycle after the ack, or a new request is accepted.
- Minimum latency from req to ack, core idle:
  - Write: 2 cycles.
  - Read: 3 cycles.
- Boundary conditions:
  - Same-address conflict: the core write wins and the host write retries, so the host value lands later (last writer wins).
  - Request changes while busy: the request is latched, so changes to i_h_* while busy are ignored and a dropped i_h_req still completes and acks.
  - Reset mid-operation: the pending request is discarded and no RAM access from it follows reset release.
- No address range checking is performed.

Optional Feature:
- Macro: QERV_RF_ARB_STARVE_EN.
- Defined:
  - A saturating counter of width $clog2(HOLD_MAX+1) counts cycles spent in PEND.
  - o_h_starve is set when the count reaches HOLD_MAX, stays set until ACK, and is cleared on leaving ACK.
  - The counter clears on entering PEND.
  - Arbitration priority is unchanged; the flag is status only.
- Undefined: no counter is built; o_h_starve is tied to 0.

Decomposition:
- Shared package qerv_rf_arb_pkg holds:
  - the state enum (IDLE, PEND, RD, ACK);
  - the default WIDTH/ADDR_W localparams derived from W and CSR count.
- No sub-module: the FSM, the latch and the muxes stay in one module.
- Integration: instantiated between serv_rf_ram_if and serv_rf_ram in the RF top.

Test Plan:
- Host write, core idle: req, we=1, addr=0x005, wdata=2'b11 at cycle 0 -> o_ram_wen=1 addr 0x005 in cycle 1; o_h_ack in cycle 2; a later host read of 0x005 returns 2'b11.
- Host read, core idle: RAM preloaded 0x120=2'b10; read req at cycle 0 -> o_ram_ren in cycle 1; o_h_ack=1 with o_h_rdata=2'b10 in cycle 3.
- Core write blocking: i_c_wen held high 6 cycles during a pending host write to 0x007 -> RAM write port carries only core traffic for those 6 cycles; host write issues in the first cycle with i_c_wen=0; ack the next cycle.
- Independent ports: core writes continuously while a host read is pending -> host read still completes in 3 cycles; core writes are unaffected.
- Reset mid-op: assert i_rst_n=0 while in RD -> o_h_ack, o_h_busy and o_h_starve are 0 immediately; no RAM enables from the host after release.
- QERV_RF_ARB_STARVE_EN with HOLD_MAX=15: core reads every cycle for 20 cycles during a host read -> o_h_starve rises after 15 PEND cycles, holds through ack, then clears.
